// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_arbiter
// Purpose  : Shares the single write port of the frame-buffer RAM among
//            NUM_REQ pixel producers. Each producer posts a burst command
//            (start address, length); grants are issued round-robin and the
//            granted producer streams pixels over valid/ready. Writes use
//            auto-incrementing addresses that wrap at FB_DEPTH.
// Ports    : vga_clk, reset          - clock, synchronous active-high reset
//            req/req_addr/req_len    - per-requester burst command
//            pix_valid/pix_data      - per-requester pixel stream in
//            pix_ready               - per-requester pixel accept
//            gnt, done               - one-hot grant, one-cycle done pulse
//            vblank                  - grant qualifier (optional feature)
//            wr_en/wr_addr/wr_data   - RAM write port
//            busy                    - arbiter not idle
// Options  : FB_ARB_VBLANK_ONLY_EN - new grants only while vblank is high
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MAX_BURST     = 64,
    parameter int LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic                     vga_clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*19-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       pix_valid,
    input  logic [NUM_REQ*24-1:0]    pix_data,
    output logic [NUM_REQ-1:0]       pix_ready,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    input  logic                     vblank,
    output logic                     wr_en,
    output logic [18:0]              wr_addr,
    output logic [23:0]              wr_data,
    output logic                     busy
);

    localparam int          c_FB_DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int          c_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [18:0] c_DEPTH19   = 19'(c_FB_DEPTH);
    localparam logic [18:0] c_LAST_ADDR = 19'(c_FB_DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BURST = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic               r_wr_en;
    logic [18:0]        r_wr_addr;
    logic [23:0]        r_wr_data;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_gidx;
    logic [18:0]        r_cur_addr;
    logic [LEN_W-1:0]   r_remaining;

    logic               w_found;
    logic [c_IDX_W-1:0] w_win;
    logic [c_IDX_W:0]   w_sum;
    logic               w_grant_ok;
    logic [18:0]        w_start;
    logic [LEN_W-1:0]   w_len;
    logic               w_beat;
    logic [c_IDX_W-1:0] w_next_ptr;

`ifdef FB_ARB_VBLANK_ONLY_EN
    assign w_grant_ok = vblank;
`else
    // vblank has no function in this build
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_grant_ok      = 1'b1;
`endif

    // Round-robin search: descending k so the lowest offset from r_rr_ptr
    // is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_sum >= (c_IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_IDX_W + 1)'(NUM_REQ);
            end
            if (req[w_sum[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_start    = req_addr[19*w_win +: 19];
    assign w_len      = req_len[LEN_W*w_win +: LEN_W];
    assign w_beat     = (r_state == c_ST_BURST) && pix_valid[r_gidx];
    assign w_next_ptr = (r_gidx == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found && w_grant_ok) begin
                        r_gidx      <= w_win;
                        r_cur_addr  <= (w_start >= c_DEPTH19) ? '0 : w_start;
                        r_remaining <= w_len;
                        if (w_len == '0) begin
                            // Empty burst: straight to the done pulse
                            r_done  <= NUM_REQ'(1) << w_win;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_gnt   <= NUM_REQ'(1) << w_win;
                            r_state <= c_ST_BURST;
                        end
                    end
                end
                c_ST_BURST: begin
                    if (w_beat) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_cur_addr;
                        r_wr_data   <= pix_data[24*r_gidx +: 24];
                        r_cur_addr  <= (r_cur_addr == c_LAST_ADDR) ? '0 : r_cur_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_W'(1)) begin
                            // done is registered, so it is high throughout DONE
                            r_done  <= r_gnt;
                            r_gnt   <= '0;
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign pix_ready = (r_state == c_ST_BURST) ? r_gnt : '0;
    assign gnt       = r_gnt;
    assign done      = r_done;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_arbiter
// Purpose  : Directed self-checking bench for fb_write_arbiter. Inputs are
//            driven and outputs sampled 1 time unit after each rising edge.
// Options  : FB_ARB_VBLANK_ONLY_EN - also runs the vblank gating scenario
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 7;
`ifdef FB_ARB_VBLANK_ONLY_EN
    localparam logic c_VB_DEFAULT = 1'b1;
`else
    localparam logic c_VB_DEFAULT = 1'b0;
`endif

    logic                     vga_clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*19-1:0]    req_addr;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       pix_valid;
    logic [NUM_REQ*24-1:0]    pix_data;
    logic [NUM_REQ-1:0]       pix_ready;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     vblank;
    logic                     wr_en;
    logic [18:0]              wr_addr;
    logic [23:0]              wr_data;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    fb_write_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .SCREEN_WIDTH (640),
        .SCREEN_HEIGHT(480),
        .MAX_BURST    (64)
    ) dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .gnt      (gnt),
        .done     (done),
        .vblank   (vblank),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [18:0] a, input logic [LEN_W-1:0] l);
        req_addr[19*i +: 19]       = a;
        req_len[LEN_W*i +: LEN_W]  = l;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req       = '0;
        req_addr  = '0;
        req_len   = '0;
        pix_valid = '0;
        pix_data  = '0;
        vblank    = c_VB_DEFAULT;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        total++; if (pix_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b exp=0000", pix_ready); end
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rst_done got=%b exp=0000", done); end
        total++; if ({wr_en, wr_addr, wr_data} !== 44'd0) begin bad++; $display("FAIL rst_wr got en=%b a=%0d d=%h exp 0", wr_en, wr_addr, wr_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_burst();
        logic [23:0] d [3];
        d[0] = 24'hAA0001; d[1] = 24'hBB0002; d[2] = 24'hCC0003;
        apply_reset();
        set_cmd(1, 19'd100, 7'd3);
        req = 4'b0010;
        pix_valid = 4'b0010;
        pix_data[24 +: 24] = d[0];
        step();
        req = 4'b0000;
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL sb_gnt got=%b exp=0010", gnt); end
        total++; if (pix_ready !== 4'b0010) begin bad++; $display("FAIL sb_ready got=%b exp=0010", pix_ready); end
        total++; if (busy !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL sb_pre got busy=%b en=%b exp busy=1 en=0", busy, wr_en); end
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) pix_data[24 +: 24] = d[k+1];
            else pix_valid = '0;
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 19'(100 + k) || wr_data !== d[k]) begin
                bad++; $display("FAIL sb_wr%0d got en=%b a=%0d d=%h exp en=1 a=%0d d=%h", k, wr_en, wr_addr, wr_data, 100 + k, d[k]);
            end
            total++;
            if (done !== ((k == 2) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL sb_done%0d got=%b", k, done); end
        end
        step();
        total++; if (done !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            bad++; $display("FAIL sb_end got done=%b en=%b busy=%b gnt=%b exp 0", done, wr_en, busy, gnt);
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_cmd(i, 19'(i * 10), 7'd1);
            pix_data[24*i +: 24] = 24'h100000 * (i + 1);
        end
        req = 4'b1111;
        pix_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            total++; if (gnt !== (4'b0001 << order[n])) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt, 4'b0001 << order[n]); end
            step();
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 19'(order[n] * 10) || wr_data !== 24'(24'h100000 * (order[n] + 1))) begin
                bad++; $display("FAIL rr_wr%0d got en=%b a=%0d d=%h exp a=%0d", n, wr_en, wr_addr, wr_data, order[n] * 10);
            end
            total++; if (done !== (4'b0001 << order[n])) begin bad++; $display("FAIL rr_done%0d got=%b exp=%b", n, done, 4'b0001 << order[n]); end
            step();
            total++; if (gnt !== 4'b0000 || done !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d got gnt=%b done=%b exp 0", n, gnt, done); end
        end
        req = '0;
        pix_valid = '0;
    endtask

    task automatic test_wrap_clamp();
        logic [18:0] ea [4];
        ea[0] = 19'd307198; ea[1] = 19'd307199; ea[2] = 19'd0; ea[3] = 19'd1;
        apply_reset();
        set_cmd(0, 19'd307198, 7'd4);
        req = 4'b0001;
        pix_valid = 4'b0001;
        pix_data[23:0] = 24'h000100;
        step();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            pix_data[23:0] = 24'(24'h000101 + k);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== ea[k] || wr_data !== 24'(24'h000100 + k)) begin
                bad++; $display("FAIL wrap%0d got en=%b a=%0d d=%h exp a=%0d d=%h", k, wr_en, wr_addr, wr_data, ea[k], 24'h000100 + k);
            end
        end
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL wrap_done got=%b exp=0001", done); end
        step();
        set_cmd(0, 19'd400000, 7'd1);
        req = 4'b0001;
        pix_data[23:0] = 24'h00ABCD;
        step();
        req = '0;
        step();
        total++; if (wr_en !== 1'b1 || wr_addr !== 19'd0 || wr_data !== 24'h00ABCD) begin
            bad++; $display("FAIL clamp got en=%b a=%0d d=%h exp en=1 a=0 d=00abcd", wr_en, wr_addr, wr_data);
        end
        total++; if (done !== 4'b0001) begin bad++; $display("FAIL clamp_done got=%b exp=0001", done); end
        pix_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_cmd(3, 19'd50, 7'd4);
        req = 4'b1000;
        pix_valid = 4'b1000;
        pix_data[72 +: 24] = 24'hD00000;
        step();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                // gap: granted lane idle, a non-granted lane pretends to send
                pix_valid = 4'b0001;
                pix_data[23:0] = 24'hEEEEEE;
                for (int g = 0; g < 3; g++) begin
                    step();
                    total++; if (wr_en !== 1'b0 || pix_ready !== 4'b1000) begin
                        bad++; $display("FAIL bp_gap%0d got en=%b ready=%b exp en=0 ready=1000", g, wr_en, pix_ready);
                    end
                end
                pix_valid = 4'b1000;
            end
            step();
            pix_data[72 +: 24] = 24'(24'hD00001 + k);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 19'(50 + k) || wr_data !== 24'(24'hD00000 + k)) begin
                bad++; $display("FAIL bp_wr%0d got en=%b a=%0d d=%h exp a=%0d d=%h", k, wr_en, wr_addr, wr_data, 50 + k, 24'hD00000 + k);
            end
        end
        total++; if (done !== 4'b1000) begin bad++; $display("FAIL bp_done got=%b exp=1000", done); end
        pix_valid = '0;
        step();
    endtask

    task automatic test_zero_len();
        apply_reset();
        set_cmd(2, 19'd5, 7'd0);
        req = 4'b0100;
        pix_valid = 4'b0100;
        step();
        req = '0;
        total++; if (done !== 4'b0100 || wr_en !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL zl_done got done=%b en=%b busy=%b exp 0100/0/1", done, wr_en, busy);
        end
        step();
        total++; if (done !== 4'b0000 || wr_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL zl_end got done=%b en=%b busy=%b exp 0/0/0", done, wr_en, busy);
        end
        pix_valid = '0;
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        // burst on lane 2 leaves the pointer at 3
        set_cmd(2, 19'd9, 7'd1);
        req = 4'b0100;
        pix_valid = 4'b0110;
        step(); req = '0;
        step(); step();
        set_cmd(1, 19'd200, 7'd5);
        req = 4'b0010;
        step(); req = '0;
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rm_gnt got=%b exp=0010", gnt); end
        step(); step();
        total++; if (wr_en !== 1'b1 || wr_addr !== 19'd201) begin bad++; $display("FAIL rm_wr got en=%b a=%0d exp en=1 a=201", wr_en, wr_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        pix_valid = '0;
        total++; if ({gnt, pix_ready, done, wr_en, wr_addr, wr_data, busy} !== 57'd0) begin
            bad++; $display("FAIL rm_clr got gnt=%b rdy=%b done=%b en=%b a=%0d d=%h busy=%b exp 0", gnt, pix_ready, done, wr_en, wr_addr, wr_data, busy);
        end
        step();
        total++; if (done !== 4'b0000) begin bad++; $display("FAIL rm_nodone got=%b exp=0000", done); end
        req = 4'b1100;
        step();
        req = '0;
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rm_regnt got=%b exp=0100", gnt); end
    endtask

`ifdef FB_ARB_VBLANK_ONLY_EN
    task automatic test_vblank();
        apply_reset();
        vblank = 1'b0;
        set_cmd(0, 19'd7, 7'd2);
        req = 4'b0001;
        pix_valid = 4'b0001;
        step(); step();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL vb_hold got gnt=%b busy=%b exp 0", gnt, busy); end
        vblank = 1'b1;
        step();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL vb_gnt got=%b exp=0001", gnt); end
        vblank = 1'b0;
        req = '0;
        step();
        total++; if (wr_en !== 1'b1 || wr_addr !== 19'd7) begin bad++; $display("FAIL vb_wr0 got en=%b a=%0d exp a=7", wr_en, wr_addr); end
        step();
        total++; if (wr_en !== 1'b1 || wr_addr !== 19'd8 || done !== 4'b0001) begin
            bad++; $display("FAIL vb_wr1 got en=%b a=%0d done=%b exp a=8 done=0001", wr_en, wr_addr, done);
        end
        pix_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_wrap_clamp();
        test_backpressure();
        test_zero_len();
        test_reset_mid_burst();
`ifdef FB_ARB_VBLANK_ONLY_EN
        test_vblank();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single write port of the 640x480x24-bit frame-buffer 2-port RAM among several pixel producers (board renderer, piece blitter, cursor overlay). Each requester posts a burst command (start address, length), is granted in round-robin order, and streams pixels over a valid/ready handshake. The arbiter issues sequential RAM writes with auto-incrementing, wrapping addresses. The VGA read side of the RAM is unaffected.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- SCREEN_WIDTH, 640: pixels per line
- SCREEN_HEIGHT, 480: lines per frame; FB_DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT
- MAX_BURST, 64: maximum pixels per burst; LEN_W = $clog2(MAX_BURST+1)
---
- vga_clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  requester i has a burst command pending
- req_addr  in  NUM_REQ*19  start address, slice i = [19*i +: 19]
- req_len  in  NUM_REQ*LEN_W  burst length in pixels, 0..MAX_BURST
- pix_valid  in  NUM_REQ  requester i presents a pixel
- pix_data  in  NUM_REQ*24  pixel {r,g,b}, slice i = [24*i +: 24]
- pix_ready  out  NUM_REQ  arbiter accepts pixel i this cycle
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle pulse, burst i finished
- vblank  in  1  vertical blanking indicator (used only with FB_ARB_VBLANK_ONLY_EN)
- wr_en  out  1  RAM write enable
- wr_addr  out  19  RAM write address
- wr_data  out  24  RAM write data
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, BURST, DONE.
- IDLE: if any req bit is set (and the grant is permitted, see Configuration), choose the winner by searching upward from rr_ptr, wrapping modulo NUM_REQ. Latch the winner's req_addr into cur_addr and req_len into remaining, set gnt to one-hot winner, then go to BURST. If the latched len is 0, go to DONE instead; no writes occur.
- BURST: pix_ready[g] = 1 (combinational from registered state), all other bits are 0. On each pix_valid[g] && pix_ready[g] beat:
  - register wr_en=1, wr_addr=cur_addr, wr_data=pix_data[g];
  - cur_addr increments, and FB_DEPTH-1 wraps to 0;
  - remaining decrements.
  - The beat that makes remaining 0 moves the FSM to DONE.
- A start address >= FB_DEPTH is reduced to 0 at latch time.
- DONE: done[g]=1 for exactly one cycle, gnt clears, rr_ptr = (g+1) mod NUM_REQ, then go to IDLE.
- Deasserting req mid-burst has no effect. The burst ends only after len beats. Requesters must hold req low after done until a new command is ready.
- pix_valid on non-granted lanes is ignored, and pix_ready stays 0 on those lanes.

## Timing
- Reset values: gnt=0, pix_ready=0, done=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, rr_ptr=0, state IDLE.
- Reset mid-burst abandons the burst; no done pulse is issued.
- req is sampled in IDLE at edge N. gnt and pix_ready are high after edge N, so the first beat can be accepted in cycle N+1.
- Write latency: a beat accepted at edge K gives wr_en high for the cycle after edge K, i.e. one cycle.
- Throughput is one pixel per cycle during BURST.
- The last beat at edge K puts the FSM in DONE after K. The done pulse lasts one cycle and IDLE is reached after K+1, so there is one dead cycle between bursts.
- Simultaneous requests are resolved only by rr_ptr order. No requester waits more than NUM_REQ-1 bursts.

## Configuration
- FB_ARB_VBLANK_ONLY_EN defined: IDLE issues a new grant only while vblank=1. A burst already in BURST runs to completion regardless of vblank.
- Not defined: vblank is ignored, and grants are issued whenever IDLE sees a request.

## Test plan
- Single burst: req[1]=1, addr=100, len=3, pix_valid held high with data A,B,C. Expect gnt=4'b0010, writes to 100/101/102 with A/B/C on consecutive cycles, then done[1] for one cycle.
- Round-robin: req=4'b1111 held, each len=1. Grant order is 0,1,2,3,0. Each done is followed by the next gnt two cycles after the prior write.
- Wrap and clamp: addr=307198, len=4 gives writes at 307198, 307199, 0, 1. addr=400000, len=1 gives a single write at 0.
- Backpressure and zero length: the granted requester drops pix_valid for 3 cycles mid-burst, so there is no wr_en in the gap and addresses stay contiguous. len=0 gives done with zero writes.
- Reset mid-burst: assert reset after 2 of 5 beats. Next cycle all outputs are 0 and no done pulse appears. A following req[2] is granted first (rr_ptr=0 scan).
- With FB_ARB_VBLANK_ONLY_EN and req[0] pending while vblank=0: no gnt. Raise vblank, and gnt appears after the next edge. Drop vblank mid-burst, and the burst still completes.
